// File: rtl/axi_pkg.sv
// Shared AXI constants, master FSM state encoding and the beat-size helper.
package axi_pkg;
   localparam logic [1:0] BURST_INCR  = 2'b01;
   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic [2:0] {IDLE, WRITE, WRESP, READ_ADDR, READ, DONE} state_e;

   function automatic logic [2:0] axi_size(input int unsigned data_width);
      return 3'($clog2(data_width / 8));
   endfunction
endpackage

// File: rtl/axi_lfsr16.sv
// 16-bit Galois LFSR (taps 16,14,13,11) producing three pseudo-random stall gates.
module axi_lfsr16 (
   input  logic       clk,
   input  logic       rst,
   output logic [2:0] gate
);
   logic [15:0] lfsr_q;
   logic [15:0] lfsr_d;

   always_comb begin
      lfsr_d = {1'b0, lfsr_q[15:1]};
      if (lfsr_q[0]) lfsr_d = lfsr_d ^ 16'hB400;
   end

   always_ff @(posedge clk) begin
      if (rst) lfsr_q <= 16'hACE1;
      else     lfsr_q <= lfsr_d;
   end

   assign gate = lfsr_q[2:0];
endmodule

// File: rtl/axi_burst_master.sv
// AXI4 master: writes one INCR burst of seed+k, reads it back and checks every beat.
// Optional random W/B/R stalling is compiled in with AXI_MASTER_RAND_STALL_EN.
module axi_burst_master
   import axi_pkg::*;
#(
   parameter int C_M_DATA_WIDTH = 32,
   parameter int C_M_ADDR_WIDTH = 8,
   parameter int C_M_ID_WIDTH   = 2
) (
   input  logic                        M_AXI_ACLK,
   input  logic                        M_AXI_ARST,
   input  logic                        start,
   input  logic [C_M_ADDR_WIDTH-1:0]   base_addr,
   input  logic [7:0]                  burst_len,
   input  logic [C_M_DATA_WIDTH-1:0]   seed,
   output logic                        busy,
   output logic                        done,
   output logic                        error,
   output logic [7:0]                  err_count,
   output logic [2:0]                  dbg_state,
   output logic                        M_AXI_AWVALID,
   output logic [C_M_ID_WIDTH-1:0]     M_AXI_AWID,
   output logic [C_M_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
   output logic [7:0]                  M_AXI_AWLEN,
   output logic [2:0]                  M_AXI_AWSIZE,
   output logic [1:0]                  M_AXI_AWBURST,
   input  logic                        M_AXI_AWREADY,
   output logic                        M_AXI_WVALID,
   output logic [C_M_DATA_WIDTH-1:0]   M_AXI_WDATA,
   output logic [C_M_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
   output logic                        M_AXI_WLAST,
   input  logic                        M_AXI_WREADY,
   input  logic                        M_AXI_BVALID,
   input  logic [C_M_ID_WIDTH-1:0]     M_AXI_BID,
   input  logic [1:0]                  M_AXI_BRESP,
   output logic                        M_AXI_BREADY,
   output logic                        M_AXI_ARVALID,
   output logic [C_M_ID_WIDTH-1:0]     M_AXI_ARID,
   output logic [C_M_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
   output logic [7:0]                  M_AXI_ARLEN,
   output logic [2:0]                  M_AXI_ARSIZE,
   output logic [1:0]                  M_AXI_ARBURST,
   input  logic                        M_AXI_ARREADY,
   input  logic                        M_AXI_RVALID,
   input  logic [C_M_ID_WIDTH-1:0]     M_AXI_RID,
   input  logic [C_M_DATA_WIDTH-1:0]   M_AXI_RDATA,
   input  logic [1:0]                  M_AXI_RRESP,
   input  logic                        M_AXI_RLAST,
   output logic                        M_AXI_RREADY
);
   localparam int DW = C_M_DATA_WIDTH;
   localparam int AW = C_M_ADDR_WIDTH;
   localparam int IW = C_M_ID_WIDTH;

   // Every channel uses VALID/READY: a transfer happens on a clock edge where both
   // are high; VALID never drops and payload never changes while waiting for READY.
   state_e          state_q, state_d;
   logic [AW-1:0]   addr_q, addr_d;
   logic [7:0]      len_q, len_d;
   logic [DW-1:0]   seed_q, seed_d;
   logic [7:0]      beat_q, beat_d;
   logic            awvalid_q, awvalid_d;
   logic            wvalid_q, wvalid_d;
   logic            aw_done_q, aw_done_d;
   logic            w_done_q, w_done_d;
   logic [IW-1:0]   awid_q, awid_d;
   logic [IW-1:0]   arid_q, arid_d;
   logic [IW-1:0]   bid_exp_q, bid_exp_d;
   logic [IW-1:0]   rid_exp_q, rid_exp_d;
   logic            error_q, error_d;
   logic [7:0]      err_count_q, err_count_d;

   logic            w_gate, b_gate, r_gate;
   logic [DW-1:0]   exp_data;
   logic            last_beat;
   logic            aw_hs, w_hs, b_hs, ar_hs, r_hs;

`ifdef AXI_MASTER_RAND_STALL_EN
   logic [2:0] gate;
   axi_lfsr16 u_lfsr (
      .clk  (M_AXI_ACLK),
      .rst  (M_AXI_ARST),
      .gate (gate)
   );
   assign w_gate = gate[0];
   assign b_gate = gate[1];
   assign r_gate = gate[2];
`else
   assign w_gate = 1'b1;
   assign b_gate = 1'b1;
   assign r_gate = 1'b1;
`endif

   assign exp_data  = seed_q + DW'(beat_q);
   assign last_beat = (beat_q == len_q);
   assign aw_hs = awvalid_q && M_AXI_AWREADY;
   assign w_hs  = wvalid_q && M_AXI_WREADY;
   assign b_hs  = M_AXI_BREADY && M_AXI_BVALID;
   assign ar_hs = M_AXI_ARVALID && M_AXI_ARREADY;
   assign r_hs  = M_AXI_RREADY && M_AXI_RVALID;

   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      len_d       = len_q;
      seed_d      = seed_q;
      beat_d      = beat_q;
      awvalid_d   = awvalid_q;
      wvalid_d    = wvalid_q;
      aw_done_d   = aw_done_q;
      w_done_d    = w_done_q;
      awid_d      = awid_q;
      arid_d      = arid_q;
      bid_exp_d   = bid_exp_q;
      rid_exp_d   = rid_exp_q;
      error_d     = error_q;
      err_count_d = err_count_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               addr_d      = base_addr;
               len_d       = burst_len;
               seed_d      = seed;
               beat_d      = 8'd0;
               awvalid_d   = 1'b1;
               wvalid_d    = 1'b1;
               aw_done_d   = 1'b0;
               w_done_d    = 1'b0;
               error_d     = 1'b0;
               err_count_d = 8'd0;
               state_d     = WRITE;
            end
         end
         WRITE: begin
            if (aw_hs) begin
               awvalid_d = 1'b0;
               aw_done_d = 1'b1;
               awid_d    = awid_q + IW'(1);
               bid_exp_d = awid_q;
            end
            // A new W beat may only be raised when the gate allows; a raised one is held.
            if (w_hs) begin
               if (last_beat) begin
                  wvalid_d = 1'b0;
                  w_done_d = 1'b1;
               end else begin
                  beat_d   = beat_q + 8'd1;
                  wvalid_d = w_gate;
               end
            end else if (!wvalid_q && !w_done_q) begin
               wvalid_d = w_gate;
            end
            if ((aw_done_q || aw_hs) && (w_done_q || (w_hs && last_beat))) begin
               beat_d  = 8'd0;
               state_d = WRESP;
            end
         end
         WRESP: begin
            if (b_hs) begin
               if ((M_AXI_BRESP != RESP_OKAY) || (M_AXI_BID != bid_exp_q)) error_d = 1'b1;
               state_d = READ_ADDR;
            end
         end
         READ_ADDR: begin
            if (ar_hs) begin
               arid_d    = arid_q + IW'(1);
               rid_exp_d = arid_q;
               beat_d    = 8'd0;
               state_d   = READ;
            end
         end
         READ: begin
            if (r_hs) begin
               if (M_AXI_RDATA != exp_data) begin
                  error_d = 1'b1;
                  if (err_count_q != 8'hFF) err_count_d = err_count_q + 8'd1;
               end
               if ((M_AXI_RRESP != RESP_OKAY) || (last_beat != M_AXI_RLAST) ||
                   (M_AXI_RID != rid_exp_q)) error_d = 1'b1;
               if (last_beat) state_d = DONE;
               else           beat_d  = beat_q + 8'd1;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge M_AXI_ACLK) begin
      if (M_AXI_ARST) begin
         state_q     <= IDLE;
         addr_q      <= '0;
         len_q       <= 8'd0;
         seed_q      <= '0;
         beat_q      <= 8'd0;
         awvalid_q   <= 1'b0;
         wvalid_q    <= 1'b0;
         aw_done_q   <= 1'b0;
         w_done_q    <= 1'b0;
         awid_q      <= '0;
         arid_q      <= '0;
         bid_exp_q   <= '0;
         rid_exp_q   <= '0;
         error_q     <= 1'b0;
         err_count_q <= 8'd0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         len_q       <= len_d;
         seed_q      <= seed_d;
         beat_q      <= beat_d;
         awvalid_q   <= awvalid_d;
         wvalid_q    <= wvalid_d;
         aw_done_q   <= aw_done_d;
         w_done_q    <= w_done_d;
         awid_q      <= awid_d;
         arid_q      <= arid_d;
         bid_exp_q   <= bid_exp_d;
         rid_exp_q   <= rid_exp_d;
         error_q     <= error_d;
         err_count_q <= err_count_d;
      end
   end

   assign busy      = (state_q != IDLE) && (state_q != DONE);
   assign done      = (state_q == DONE);
   assign error     = error_q;
   assign err_count = err_count_q;
   assign dbg_state = state_q;

   assign M_AXI_AWVALID = awvalid_q;
   assign M_AXI_AWID    = awid_q;
   assign M_AXI_AWADDR  = addr_q;
   assign M_AXI_AWLEN   = len_q;
   assign M_AXI_AWSIZE  = axi_size(DW);
   assign M_AXI_AWBURST = BURST_INCR;
   assign M_AXI_WVALID  = wvalid_q;
   assign M_AXI_WDATA   = exp_data;
   assign M_AXI_WSTRB   = '1;
   assign M_AXI_WLAST   = last_beat;
   assign M_AXI_BREADY  = (state_q == WRESP) && b_gate;
   assign M_AXI_ARVALID = (state_q == READ_ADDR);
   assign M_AXI_ARID    = arid_q;
   assign M_AXI_ARADDR  = addr_q;
   assign M_AXI_ARLEN   = len_q;
   assign M_AXI_ARSIZE  = axi_size(DW);
   assign M_AXI_ARBURST = BURST_INCR;
   assign M_AXI_RREADY  = (state_q == READ) && r_gate;
endmodule

// File: tb/tb_axi_burst_master.sv
// Bench for axi_burst_master: memory-backed AXI slave, transaction-level model and directed bursts.
module tb_axi_burst_master;
   import axi_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [7:0]  base_addr = 8'd0;
   logic [7:0]  burst_len = 8'd0;
   logic [31:0] seed = 32'd0;
   logic        busy, done, error;
   logic [7:0]  err_count;
   logic [2:0]  dbg_state;
   logic        M_AXI_AWVALID, M_AXI_WVALID, M_AXI_WLAST, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY;
   logic [1:0]  M_AXI_AWID, M_AXI_ARID, M_AXI_AWBURST, M_AXI_ARBURST;
   logic [7:0]  M_AXI_AWADDR, M_AXI_AWLEN, M_AXI_ARADDR, M_AXI_ARLEN;
   logic [2:0]  M_AXI_AWSIZE, M_AXI_ARSIZE;
   logic [31:0] M_AXI_WDATA;
   logic [3:0]  M_AXI_WSTRB;
   logic        M_AXI_AWREADY = 1'b0, M_AXI_WREADY = 1'b0, M_AXI_ARREADY = 1'b0;
   logic        M_AXI_BVALID = 1'b0, M_AXI_RVALID = 1'b0, M_AXI_RLAST = 1'b0;
   logic [1:0]  M_AXI_BID = 2'd0, M_AXI_BRESP = 2'd0, M_AXI_RID = 2'd0, M_AXI_RRESP = 2'd0;
   logic [31:0] M_AXI_RDATA = 32'd0;

   int checks = 0;
   int errors = 0;

   // transaction configuration and expected write stream
   logic [7:0]  cfg_base;
   int          cfg_len, cfg_corrupt, cfg_aw_delay;
   logic [1:0]  cfg_bresp;
   logic [31:0] exp_q[$];

   // slave state
   logic [31:0] mem [256];
   bit          aw_seen, w_last_seen, b_issued, b_pending, b_done, r_active, aw_wait, reset_check;
   int          w_cnt, r_cnt, since_w, aw_hs_since;
   logic [1:0]  aw_id_seen, ar_id_seen, first_awid;
   logic [7:0]  aw_addr_h, aw_len_h;
   logic [1:0]  aw_id_h;
   logic [31:0] first_wdata;

   // transaction-level model of the master
   bit          m_busy, m_done, m_error;
   int          m_errcnt, done_cnt;
   logic [1:0]  m_awid, m_arid;

   axi_burst_master #(.C_M_DATA_WIDTH(32), .C_M_ADDR_WIDTH(8), .C_M_ID_WIDTH(2)) dut (
      .M_AXI_ACLK(clk), .M_AXI_ARST(rst), .start(start), .base_addr(base_addr),
      .burst_len(burst_len), .seed(seed), .busy(busy), .done(done), .error(error),
      .err_count(err_count), .dbg_state(dbg_state),
      .M_AXI_AWVALID(M_AXI_AWVALID), .M_AXI_AWID(M_AXI_AWID), .M_AXI_AWADDR(M_AXI_AWADDR),
      .M_AXI_AWLEN(M_AXI_AWLEN), .M_AXI_AWSIZE(M_AXI_AWSIZE), .M_AXI_AWBURST(M_AXI_AWBURST),
      .M_AXI_AWREADY(M_AXI_AWREADY), .M_AXI_WVALID(M_AXI_WVALID), .M_AXI_WDATA(M_AXI_WDATA),
      .M_AXI_WSTRB(M_AXI_WSTRB), .M_AXI_WLAST(M_AXI_WLAST), .M_AXI_WREADY(M_AXI_WREADY),
      .M_AXI_BVALID(M_AXI_BVALID), .M_AXI_BID(M_AXI_BID), .M_AXI_BRESP(M_AXI_BRESP),
      .M_AXI_BREADY(M_AXI_BREADY), .M_AXI_ARVALID(M_AXI_ARVALID), .M_AXI_ARID(M_AXI_ARID),
      .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARLEN(M_AXI_ARLEN), .M_AXI_ARSIZE(M_AXI_ARSIZE),
      .M_AXI_ARBURST(M_AXI_ARBURST), .M_AXI_ARREADY(M_AXI_ARREADY), .M_AXI_RVALID(M_AXI_RVALID),
      .M_AXI_RID(M_AXI_RID), .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP),
      .M_AXI_RLAST(M_AXI_RLAST), .M_AXI_RREADY(M_AXI_RREADY)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic slave_clear();
      aw_seen = 0; w_last_seen = 0; b_issued = 0; b_pending = 0; b_done = 0;
      r_active = 0; aw_wait = 0; w_cnt = 0; r_cnt = 0; since_w = 0; aw_hs_since = 0;
   endtask

   // Slave and compare process: everything is evaluated on the falling edge, where
   // DUT outputs are stable; a handshake seen here completes on the next rising edge.
   initial begin : slave_and_compare
      bit          done_now;
      logic [31:0] exp_w;
      forever begin
         @(negedge clk);
         if (reset_check) begin
            chk("rst_awvalid", M_AXI_AWVALID, 0);
            chk("rst_wvalid", M_AXI_WVALID, 0);
            chk("rst_arvalid", M_AXI_ARVALID, 0);
            chk("rst_bready", M_AXI_BREADY, 0);
            chk("rst_rready", M_AXI_RREADY, 0);
            reset_check = 0;
         end
         chk("busy", busy, m_busy);
         chk("done", done, m_done);
         done_now = m_done;
         if (m_done) begin
            chk("done_error", error, m_error);
            chk("done_err_count", err_count, m_errcnt);
            done_cnt++;
            m_done = 0;
         end
         if (rst) begin
            slave_clear();
            exp_q.delete();
            m_busy = 0; m_done = 0; m_error = 0; m_errcnt = 0; m_awid = 0; m_arid = 0;
            M_AXI_AWREADY = 0; M_AXI_WREADY = 0; M_AXI_ARREADY = 0;
            M_AXI_BVALID = 0; M_AXI_RVALID = 0; M_AXI_RLAST = 0;
            reset_check = 1;
         end else begin
            if (start && !m_busy && !done_now) begin
               m_busy = 1; m_error = 0; m_errcnt = 0;
            end
            if (aw_seen && w_last_seen && !b_issued) begin
               b_pending = 1; b_issued = 1;
            end
            if (w_last_seen) since_w++;
            M_AXI_AWREADY = (cfg_aw_delay == 0) || (w_last_seen && since_w > cfg_aw_delay);
            M_AXI_WREADY  = 1;
            M_AXI_ARREADY = 1;
            M_AXI_BVALID  = b_pending;
            M_AXI_BID     = aw_id_seen;
            M_AXI_BRESP   = cfg_bresp;
            M_AXI_RVALID  = r_active;
            M_AXI_RID     = ar_id_seen;
            M_AXI_RRESP   = RESP_OKAY;
            M_AXI_RDATA   = mem[r_cnt[7:0]] ^ ((r_cnt == cfg_corrupt) ? 32'd1 : 32'd0);
            M_AXI_RLAST   = (r_cnt == cfg_len);

            if (aw_seen) chk("aw_once", M_AXI_AWVALID, 0);
            if (aw_wait) chk("aw_held", M_AXI_AWVALID, 1);
            if (M_AXI_AWVALID && !aw_seen) begin
               if (aw_wait) begin
                  chk("aw_stable_addr", M_AXI_AWADDR, aw_addr_h);
                  chk("aw_stable_len", M_AXI_AWLEN, aw_len_h);
                  chk("aw_stable_id", M_AXI_AWID, aw_id_h);
               end
               if (M_AXI_AWREADY) begin
                  chk("awaddr", M_AXI_AWADDR, cfg_base);
                  chk("awlen", M_AXI_AWLEN, cfg_len[7:0]);
                  chk("awid", M_AXI_AWID, m_awid);
                  chk("awsize", M_AXI_AWSIZE, 3'd2);
                  chk("awburst", M_AXI_AWBURST, 2'b01);
                  aw_seen = 1; aw_wait = 0; aw_id_seen = M_AXI_AWID;
                  first_awid = M_AXI_AWID; aw_hs_since = since_w;
                  m_awid = m_awid + 2'd1;
               end else begin
                  aw_wait = 1;
                  aw_addr_h = M_AXI_AWADDR; aw_len_h = M_AXI_AWLEN; aw_id_h = M_AXI_AWID;
                  if (w_last_seen) begin
                     chk("stall_bready", M_AXI_BREADY, 0);
                     chk("stall_arvalid", M_AXI_ARVALID, 0);
                  end
               end
            end
            if (M_AXI_WVALID && M_AXI_WREADY) begin
               if (exp_q.size() == 0) begin
                  chk("w_extra_beat", M_AXI_WVALID, 0);
               end else begin
                  exp_w = exp_q.pop_front();
                  chk("wdata", M_AXI_WDATA, exp_w);
                  chk("wlast", M_AXI_WLAST, (w_cnt == cfg_len));
                  chk("wstrb", M_AXI_WSTRB, 4'hF);
                  mem[w_cnt[7:0]] = M_AXI_WDATA;
                  if (w_cnt == 0) first_wdata = M_AXI_WDATA;
                  w_cnt++;
                  if (w_cnt == cfg_len + 1) w_last_seen = 1;
               end
            end
            if (M_AXI_BVALID && M_AXI_BREADY) begin
               b_pending = 0; b_done = 1;
               if (cfg_bresp != RESP_OKAY) m_error = 1;
            end
            if (M_AXI_ARVALID && M_AXI_ARREADY) begin
               chk("ar_after_b", b_done, 1);
               chk("araddr", M_AXI_ARADDR, cfg_base);
               chk("arlen", M_AXI_ARLEN, cfg_len[7:0]);
               chk("arid", M_AXI_ARID, m_arid);
               chk("arsize", M_AXI_ARSIZE, 3'd2);
               chk("arburst", M_AXI_ARBURST, 2'b01);
               m_arid = m_arid + 2'd1;
               ar_id_seen = M_AXI_ARID; r_active = 1; r_cnt = 0;
            end
            if (M_AXI_RVALID && M_AXI_RREADY) begin
               if (r_cnt == cfg_corrupt) begin
                  m_error = 1;
                  if (m_errcnt < 255) m_errcnt++;
               end
               r_cnt++;
               if (r_cnt > cfg_len) begin
                  r_active = 0; m_done = 1; m_busy = 0;
               end
            end
         end
      end
   end

   task automatic run_txn(input logic [7:0] b, input int l, input logic [31:0] s,
                          input logic [1:0] br, input int corrupt, input int awd);
      cfg_base = b; cfg_len = l; cfg_bresp = br; cfg_corrupt = corrupt; cfg_aw_delay = awd;
      slave_clear();
      for (int k = 0; k <= l; k++) exp_q.push_back(s + 32'(k));
      @(posedge clk); #2;
      base_addr = b; burst_len = l[7:0]; seed = s; start = 1;
      @(posedge clk); #2;
      start = 0;
   endtask

   task automatic pulse_start(input logic [7:0] b, input logic [7:0] l, input logic [31:0] s);
      @(posedge clk); #2;
      base_addr = b; burst_len = l; seed = s; start = 1;
      @(posedge clk); #2;
      start = 0;
   endtask

   task automatic wait_done(input string name);
      int n;
      int target;
      target = done_cnt + 1;
      n = 0;
      while (done_cnt < target && n < 2000) begin
         @(posedge clk);
         n++;
      end
      chk({name, "_done_seen"}, (done_cnt >= target), 1);
      @(negedge clk);
   endtask

   initial begin : main
      int n;
      cfg_base = 0; cfg_len = 0; cfg_bresp = 0; cfg_corrupt = -1; cfg_aw_delay = 0;
      repeat (3) @(posedge clk);
      #2 rst = 0;
      @(negedge clk); #1;
      chk("reset_busy", busy, 0);
      chk("reset_done", done, 0);
      chk("reset_error", error, 0);
      chk("reset_err_count", err_count, 0);
      chk("reset_awid", M_AXI_AWID, 0);
      chk("reset_arid", M_AXI_ARID, 0);
      chk("reset_state", dbg_state, IDLE);

      // 64-beat burst from address 0, data 0..63
      run_txn(8'h00, 63, 32'd0, RESP_OKAY, -1, 0);
      wait_done("t1");
      chk("t1_wbeats", w_cnt, 64);
      chk("t1_first_wdata", first_wdata, 32'd0);
      chk("t1_error", error, 0);
      chk("t1_err_count", err_count, 0);

      // single-beat burst
      run_txn(8'h40, 0, 32'hDEADBEEF, RESP_OKAY, -1, 0);
      wait_done("t2");
      chk("t2_first_wdata", first_wdata, 32'hDEADBEEF);
      chk("t2_wbeats", w_cnt, 1);
      chk("t2_error", error, 0);

      // read beat 5 corrupted
      run_txn(8'h10, 15, 32'd100, RESP_OKAY, 5, 0);
      wait_done("t3");
      chk("t3_err_count", err_count, 8'd1);
      chk("t3_error", error, 1);

      // SLVERR write response, read still runs
      run_txn(8'h20, 3, 32'h0000_1234, RESP_SLVERR, -1, 0);
      wait_done("t4");
      chk("t4_error", error, 1);
      chk("t4_err_count", err_count, 0);
      chk("t4_rbeats", r_cnt, 4);

      // AWREADY held off until 20 cycles after the last W beat; seed wraps; stray start ignored
      run_txn(8'h80, 7, 32'hFFFF_FFFC, RESP_OKAY, -1, 20);
      repeat (3) @(posedge clk);
      pulse_start(8'hEE, 8'd2, 32'd55);
      wait_done("t5");
      chk("t5_aw_after_stall", aw_hs_since, 21);
      chk("t5_error", error, 0);

      // reset in the middle of the read phase
      run_txn(8'h30, 15, 32'h1000, RESP_OKAY, -1, 0);
      n = 0;
      while (!(r_active && r_cnt == 3) && n < 2000) begin
         @(posedge clk);
         n++;
      end
      chk("t6_reached_read_beat3", (r_active && r_cnt == 3), 1);
      #2 rst = 1;
      @(posedge clk); #2 rst = 0;
      repeat (3) @(negedge clk);
      chk("t6_after_reset_error", error, 0);
      run_txn(8'h50, 3, 32'd7, RESP_OKAY, -1, 0);
      wait_done("t6");
      chk("t6_awid_after_reset", first_awid, 2'd0);
      chk("t6_error", error, 0);

      repeat (3) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/axi_burst_master.md
Name: axi_burst_master

Overview:
AXI4 full master that writes one INCR burst and reads it back for self-check. It is the initiator counterpart to axi_slave. On a start pulse it writes a seeded incrementing pattern to base_addr, waits for the write response, reads the same burst back and compares every beat. It reports done, error and mismatch count, and serves as the reusable traffic generator and checker for slave bring-up.

Parameters:
C_M_DATA_WIDTH, 32, data bus width in bits (multiple of 8)
C_M_ADDR_WIDTH, 8, byte address width
C_M_ID_WIDTH, 2, AXI ID width

Ports:
M_AXI_ACLK  in  1  clock
M_AXI_ARST  in  1  synchronous active-high reset
start  in  1  one-cycle request; ignored while busy
base_addr  in  AW  burst start address, sampled at start
burst_len  in  8  AXI LEN (beats-1), sampled at start
seed  in  DW  first data word, sampled at start
busy  out  1  transaction in progress
done  out  1  one-cycle pulse at completion
error  out  1  sticky until next start: any mismatch, non-OKAY BRESP/RRESP, or RLAST misplaced
err_count  out  8  count of mismatching read beats, saturates at 255
M_AXI_AW{VALID,ID,ADDR,LEN,SIZE,BURST} out, AWREADY in: AW channel
M_AXI_W{VALID,DATA,STRB,LAST} out, WREADY in: W channel
M_AXI_B{VALID,ID,RESP} in, BREADY out: B channel
M_AXI_AR{VALID,ID,ADDR,LEN,SIZE,BURST} out, ARREADY in: AR channel
M_AXI_R{VALID,ID,DATA,RESP,LAST} in, RREADY out: R channel

Behaviour:
- Clocking and reset: one clock, M_AXI_ACLK. Reset is synchronous and active-high on M_AXI_ARST.
- Reset values: all VALIDs, BREADY, RREADY, busy, done and error are 0. err_count is 0. IDs are 0. State is IDLE.
- Reset mid-burst: all VALIDs drop on the next edge. No completion is reported.
- Constants: AWBURST/ARBURST = 2'b01 (INCR). SIZE = clog2(DW/8). WSTRB is all ones.
- IDs: AWID and ARID are per-channel counters that increment on each AW/AR handshake and wrap.
- IDLE: on start, latch the inputs, clear error and err_count, set busy and go to WRITE.
- WRITE: AWVALID and WVALID assert together on entry.
  - AWVALID holds until AWREADY and does not reassert for this transaction.
  - WDATA for beat k = seed + k, modulo 2^DW.
  - WLAST = (k == len). With burst_len = 0, WLAST is on the first beat.
  - A VALID never drops before its handshake, and payload is stable while VALID && !READY.
  - W may complete before AW. Exit to WRESP only when both AW is done and the WLAST beat has been accepted, including when both finish in the same cycle.
- WRESP: BREADY = 1. On BVALID, error |= (BRESP != 2'b00) | (BID != latched AWID). Then go to READ_ADDR.
- READ_ADDR: ARVALID = 1, ARADDR = base_addr, ARLEN = len. On handshake go to READ.
- READ: RREADY = 1. On each R beat k:
  - compare RDATA to seed + k; on mismatch, err_count++ (saturating) and error = 1;
  - error |= (RRESP != 0) | ((k == len) != RLAST) | (RID != ARID).
  - On the beat with k == len, go to DONE.
- DONE: one cycle. done = 1, busy = 0, then IDLE.
- Latency: with always-ready slave, AW/W take len+1 cycles, then B, AR and len+1 R beats.
- Beat counter: 8 bits, shared by the W and R phases, cleared on phase entry.
- start in DONE or any busy state is dropped.

Optional Feature:
Macro AXI_MASTER_RAND_STALL_EN.
- Defined: a 16-bit LFSR (seeded 16'hACE1 at reset) gates three things:
  - the raising of WVALID for a new beat;
  - BREADY;
  - RREADY.
  - Once raised, VALID stays asserted until its handshake (protocol-legal).
- Undefined: no LFSR logic. WVALID is continuous and the READYs are constant 1 in their states.

Decomposition:
- Package axi_pkg:
  - BURST_INCR, RESP_OKAY, RESP_SLVERR;
  - state enum {IDLE, WRITE, WRESP, READ_ADDR, READ, DONE};
  - size function clog2(DW/8).
- Sub-module axi_lfsr16: instantiated only under the macro. Galois taps 16,14,13,11; outputs 3 gate bits.

Test Plan:
- Ideal slave, base 0x00, len 63, seed 0: 64 W beats with data 0..63, WLAST on beat 63; read returns the same → done after the last R, error = 0, err_count = 0.
- len 0, seed 0xDEADBEEF: WLAST on the single beat, RLAST on the single R → done, error = 0.
- Slave that corrupts R beat 5 (xor 1), len 15 → err_count = 1, error = 1, done still pulses.
- Slave returns BRESP = 2'b10 → error = 1, and the read phase still runs.
- AWREADY delayed 20 cycles after all W beats are accepted → no exit from WRITE until the AW handshake; payload stable throughout the stall.
- M_AXI_ARST asserted during READ beat 3 → next cycle all VALIDs = 0, busy = 0. A subsequent start runs cleanly with AWID = 0.
